// File: rtl/ex_mem_bridge.sv
// ex_mem_bridge: turns the core's single-cycle execute-stage memory access
// into a registered request/grant/rvalid bus transaction. The pipeline is
// frozen through hold_o until the access completes.
// Optional feature: define EX_BRIDGE_TIMEOUT_EN to add a bus-wait watchdog
// that forces completion after TIMEOUT_CYC cycles and pulses err_o.
//
// Handshake contract: a request is accepted in the cycle m_req_o && m_gnt_i.
// m_we_o/m_addr_o/m_wdata_o are stable while m_req_o is high. A read response
// is accepted only in the cycle after grant or later (m_rvalid_i is ignored
// while the request is still being granted).
module ex_mem_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_req_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  output logic [DATA_W-1:0] ex_rdata_o,
  output logic              hold_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_gnt_i,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_hold;
  logic                w_cap_req;
  logic                w_cap_rd;
  logic                w_timeout;
  logic                w_wait_hit;

`ifdef EX_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_wait_hit = ((r_state == S_REQ) || (r_state == S_RESP)) &&
                      (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter: cleared when a request is launched, counts REQ/RESP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_cap_req) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Error pulse is high exactly in the DONE cycle produced by a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC < 2);
  assign w_wait_hit   = 1'b0;
  assign err_o        = 1'b0;
`endif

  // Next-state and hold: hold is combinational in IDLE so the core freezes
  // in the very cycle it presents the access.
  always_comb begin
    w_next    = r_state;
    w_hold    = 1'b0;
    w_cap_req = 1'b0;
    w_cap_rd  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_hold = ex_req_i;
        if (ex_req_i) begin
          w_cap_req = 1'b1;
          w_next    = S_REQ;
        end
      end
      S_REQ: begin
        w_hold = 1'b1;
        if (m_gnt_i) begin
          w_next = r_we ? S_DONE : S_RESP;
        end
      end
      S_RESP: begin
        w_hold = 1'b1;
        if (m_rvalid_i) begin
          w_cap_rd = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE: begin
        // ex_req_i deliberately not sampled: the core still shows the same
        // instruction's request here and it must not be issued twice.
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A normal completion in the final wait cycle wins over the watchdog.
    if (w_wait_hit && (w_next != S_DONE)) begin
      w_next    = S_DONE;
      w_timeout = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture: bus-side fields are frozen from IDLE until grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_cap_req) begin
      r_we    <= ex_we_i;
      r_addr  <= ex_addr_i;
      r_wdata <= ex_wdata_i;
    end
  end

  // Read data: updated only by a completed read (or zeroed by a read timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_cap_rd) begin
      r_rdata <= m_rdata_i;
    end else if (w_timeout && !r_we) begin
      r_rdata <= '0;
    end
  end

  assign m_req_o     = (r_state == S_REQ);
  assign m_we_o      = r_we;
  assign m_addr_o    = r_addr;
  assign m_wdata_o   = r_wdata;
  assign ex_rdata_o  = r_rdata;
  assign hold_o      = w_hold;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_ex_mem_bridge.sv
// Bench for ex_mem_bridge: directed accesses, a transaction-level model of
// the expected bus requests and read data, and a per-cycle compare process.
module tb_ex_mem_bridge;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int REQ_W = 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ex_req_i, ex_we_i;
  logic [AW-1:0] ex_addr_i;
  logic [DW-1:0] ex_wdata_i, ex_rdata_o;
  logic          hold_o, m_req_o, m_we_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o, m_rdata_i;
  logic          m_gnt_i, m_rvalid_i, err_o;
  logic [1:0]    dbg_state_o;

  ex_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .ex_req_i(ex_req_i), .ex_we_i(ex_we_i), .ex_addr_i(ex_addr_i),
    .ex_wdata_i(ex_wdata_i), .ex_rdata_o(ex_rdata_o), .hold_o(hold_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i),
    .m_rdata_i(m_rdata_i), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- model / scoreboard ----------------
  int               n_cmp = 0;
  int               n_bad = 0;
  int               hs_cnt = 0;
  logic             in_txn = 1'b0;
  logic [DW-1:0]    exp_rdata = '0;
  logic             exp_err = 1'b0;
  logic [REQ_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, checked away from the active edge.
  always @(negedge clk) begin
    chk("ex_rdata", 128'(ex_rdata_o), 128'(exp_rdata));
    chk("err", 128'(err_o), 128'(exp_err));
    if (!in_txn) begin
      chk("idle_hold", 128'(hold_o), 128'(0));
      chk("idle_m_req", 128'(m_req_o), 128'(0));
    end
    if (m_req_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_m_req", 128'(1), 128'(0));
      end else begin
        chk("m_req_fields", 128'({m_we_o, m_addr_o, m_wdata_o}), 128'(exp_q[0]));
        if (m_gnt_i) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of the IDLE cycle that presents the access.
  task automatic do_access(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int gnt_dly,
                           input int rv_dly, input logic [DW-1:0] rdata,
                           input logic keep_req, input logic junk_rv,
                           output int holds);
    int n_exp;
    holds = 0;
    ex_req_i = 1'b1; ex_we_i = we; ex_addr_i = addr; ex_wdata_i = wdata;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    in_txn = 1'b1;
    exp_q.push_back({we, addr, wdata});
    @(negedge clk);
    if (hold_o) holds++;
    for (int c = 0; c <= gnt_dly; c++) begin
      step();
      if (!keep_req) begin
        ex_req_i = 1'b0; ex_we_i = 1'($urandom);
        ex_addr_i = $urandom; ex_wdata_i = $urandom;
      end
      m_gnt_i    = (c == gnt_dly);
      m_rvalid_i = junk_rv && (c == gnt_dly);
      m_rdata_i  = 32'hBAD0BAD0;
      @(negedge clk);
      if (hold_o) holds++;
    end
    if (!we) begin
      for (int c = 0; c <= rv_dly; c++) begin
        step();
        m_gnt_i    = 1'b0;
        m_rvalid_i = (c == rv_dly);
        m_rdata_i  = (c == rv_dly) ? rdata : $urandom;
        @(negedge clk);
        if (hold_o) holds++;
      end
    end
    step();
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0;
    in_txn = 1'b0;
    if (!we) exp_rdata = rdata;
    if (!keep_req) ex_req_i = 1'b0;
    @(negedge clk);
    n_exp = 1 + (gnt_dly + 1) + (we ? 0 : rv_dly + 1);
    chk("hold_cycles", 128'(holds), 128'(n_exp));
    chk("hold_done", 128'(hold_o), 128'(0));
  endtask

  // ---------------- directed vectors ----------------
  logic          v_we[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [AW-1:0] v_addr[4] = '{32'h0000_0100, 32'h0000_0104, 32'hFFFF_FFFC, 32'h8000_0000};
  logic [DW-1:0] v_data[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'h5555_AAAA};
  int            v_gd[4]   = '{2, 1, 3, 0};
  int            v_rd[4]   = '{3, 0, 1, 0};

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    int hs0;
    rst = 1'b1;
    ex_req_i = 1'b0; ex_we_i = 1'b0; ex_addr_i = '0; ex_wdata_i = '0;
    m_gnt_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", 128'(m_req_o), 128'(0));
    chk("rst_m_we", 128'(m_we_o), 128'(0));
    chk("rst_m_addr", 128'(m_addr_o), 128'(0));
    chk("rst_m_wdata", 128'(m_wdata_o), 128'(0));
    chk("rst_ex_rdata", 128'(ex_rdata_o), 128'(0));
    chk("rst_err", 128'(err_o), 128'(0));
    chk("rst_hold", 128'(hold_o), 128'(0));
    step();
    rst = 1'b0;
    step();

    // Read, zero wait states.
    do_access(1'b0, 32'h1000_0004, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, h);
    chk("rd0_hold_lit", 128'(h), 128'(3));
    chk("rd0_data_lit", 128'(ex_rdata_o), 128'(32'hDEADBEEF));

    // Write with a 3-cycle grant delay: read data must not move.
    step();
    do_access(1'b1, 32'h2000_0000, 32'h12345678, 3, 0, 32'h0, 1'b0, 1'b0, h);
    chk("wr3_hold_lit", 128'(h), 128'(5));
    chk("wr3_rdata_lit", 128'(ex_rdata_o), 128'(32'hDEADBEEF));

    // Back-to-back read then write, request held high throughout; the read
    // also sees an illegal rvalid in its grant cycle that must be ignored.
    step();
    hs0 = hs_cnt;
    do_access(1'b0, 32'h1000_0040, 32'h0, 1, 2, 32'hA5A55A5A, 1'b1, 1'b1, h);
    step();
    do_access(1'b1, 32'h1000_0044, 32'h0BADF00D, 0, 0, 32'h0, 1'b1, 1'b0, h);
    chk("b2b_hold_lit", 128'(h), 128'(2));
    step();
    ex_req_i = 1'b0;
    repeat (3) step();
    chk("b2b_handshakes", 128'(hs_cnt - hs0), 128'(2));
    chk("b2b_rdata_lit", 128'(ex_rdata_o), 128'(32'hA5A55A5A));

    // Idle: no requests for 20 cycles (compare process checks each cycle).
    hs0 = hs_cnt;
    repeat (20) step();
    chk("idle_handshakes", 128'(hs_cnt - hs0), 128'(0));

    // Directed table with assorted wait states.
    for (int i = 0; i < 4; i++) begin
      do_access(v_we[i], v_addr[i], v_data[i], v_gd[i], v_rd[i],
                v_data[i] ^ 32'h0F0F_0F0F, 1'b0, 1'b0, h);
      step();
    end
    chk("tbl_rdata_lit", 128'(ex_rdata_o), 128'(32'h8F0F_0F0E));

`ifdef EX_BRIDGE_TIMEOUT_EN
    // Read that is granted but never answered: times out 8 cycles after REQ entry.
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h4000_0000; ex_wdata_i = '0;
    in_txn = 1'b1;
    exp_q.push_back({1'b0, 32'h4000_0000, 32'h0});
    @(negedge clk);
    step();
    ex_req_i = 1'b0; m_gnt_i = 1'b1;
    @(negedge clk);
    for (int c = 2; c <= 8; c++) begin
      step();
      m_gnt_i = 1'b0;
      @(negedge clk);
      chk("to_hold", 128'(hold_o), 128'(1));
    end
    step();
    in_txn = 1'b0; exp_err = 1'b1; exp_rdata = '0;
    m_rvalid_i = 1'b1; m_rdata_i = 32'h7777_7777;
    @(negedge clk);
    chk("to_err_lit", 128'(err_o), 128'(1));
    chk("to_hold_rel", 128'(hold_o), 128'(0));
    step();
    exp_err = 1'b0; m_rvalid_i = 1'b0;
    repeat (2) step();
    chk("to_rdata_lit", 128'(ex_rdata_o), 128'(0));
    // Restore a non-zero read value so the reset test below is meaningful.
    do_access(1'b0, 32'h1000_0008, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0, h);
    step();
`endif

    // Reset while waiting for rvalid.
    ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h3000_0000; ex_wdata_i = '0;
    in_txn = 1'b1;
    exp_q.push_back({1'b0, 32'h3000_0000, 32'h0});
    @(negedge clk);
    step();
    m_gnt_i = 1'b1;
    @(negedge clk);
    step();
    m_gnt_i = 1'b0;
    @(negedge clk);
    chk("rst_pre_hold", 128'(hold_o), 128'(1));
    step();
    #1;
    rst = 1'b1;
    ex_req_i = 1'b0;
    #1;
    chk("rst_mid_m_req", 128'(m_req_o), 128'(0));
    chk("rst_mid_hold", 128'(hold_o), 128'(0));
    chk("rst_mid_rdata", 128'(ex_rdata_o), 128'(0));
    exp_rdata = '0; in_txn = 1'b0; exp_q.delete();
    m_rvalid_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
    repeat (2) step();
    rst = 1'b0;
    step();
    m_rvalid_i = 1'b0;
    repeat (3) step();
    chk("rst_late_rv_lit", 128'(ex_rdata_o), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_bridge.md
Name: ex_mem_bridge

Overview:
- Data-side bus bridge between the core's execute-stage memory port (rib_ex_*) and a split request/grant/response system bus.
- Converts the core's single-cycle combinational access into a registered request/grant/rvalid transaction.
- Freezes the pipeline through the hold-flag input of the core's ctrl path until each access completes.
- Sits directly downstream of the core top, in the SoC top; one bridge per core.

Parameters:
- ADDR_W, 32, address width; matches MemAddrBus.
- DATA_W, 32, data width; matches MemBus.
- TIMEOUT_CYC, 256, bus-wait cycles before forced completion; used only when the optional feature is compiled in; must be ≥2.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- ex_req_i  in  1  core access request (rib_ex_req_o).
- ex_we_i  in  1  core write flag (rib_ex_we_o).
- ex_addr_i  in  ADDR_W  core access address (rib_ex_addr_o).
- ex_wdata_i  in  DATA_W  core write data (rib_ex_data_o).
- ex_rdata_o  out  DATA_W  read data to core (rib_ex_data_i).
- hold_o  out  1  pipeline hold to core (rib_hold_flag_i).
- m_req_o  out  1  bus request valid.
- m_we_o  out  1  bus write flag.
- m_addr_o  out  ADDR_W  bus address.
- m_wdata_o  out  DATA_W  bus write data.
- m_gnt_i  in  1  bus grant; request accepted in the cycle m_req_o&m_gnt_i.
- m_rvalid_i  in  1  read response valid.
- m_rdata_i  in  DATA_W  read response data.
- err_o  out  1  one-cycle timeout pulse; tied 0 without the optional feature.

Behaviour:
- States: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- Reset values: m_req_o=0, m_we_o=0, m_addr_o=0, m_wdata_o=0, ex_rdata_o=0, err_o=0.
- Reset is asynchronous; asserting it mid-transaction aborts to IDLE, drops m_req_o immediately, and discards any pending response.
- IDLE:
  - On ex_req_i=1, capture ex_we_i, ex_addr_i and ex_wdata_i into the m_* registers, then go to REQ.
  - hold_o = ex_req_i, combinational, so the core freezes in the same cycle.
- REQ:
  - m_req_o=1; m_addr_o, m_we_o and m_wdata_o stay stable until grant.
  - On m_gnt_i=1: write goes to DONE; read goes to RESP. m_req_o drops the cycle after grant.
  - hold_o=1.
- RESP:
  - m_req_o=0. On m_rvalid_i=1, register m_rdata_i into ex_rdata_o and go to DONE.
  - An rvalid that arrives in the same cycle as the grant is not legal bus behaviour and is ignored.
  - hold_o=1.
- DONE:
  - hold_o=0; ex_rdata_o holds the captured data so the core writes back this cycle.
  - Always returns to IDLE. ex_req_i is not re-sampled here, which prevents re-issuing the same instruction's access.
- ex_rdata_o holds its last value until the next read completes; writes leave it unchanged.
- Minimum latency: write 2 hold cycles; read 3 hold cycles (no wait states).
- ex_req_i=0 in IDLE: hold_o=0 and no bus activity.
- ex_req_i deasserting while in REQ or RESP (e.g. jtag halt) does not cancel; the transaction completes.
- Back-to-back accesses: the next access is accepted in the IDLE cycle right after DONE.

Optional Feature:
- EX_BRIDGE_TIMEOUT_EN defined:
  - A wait counter clears on entry to REQ and increments each cycle in REQ or RESP.
  - On reaching TIMEOUT_CYC-1 the bridge goes to DONE, forces ex_rdata_o=0 (reads only), drops m_req_o, and pulses err_o for 1 cycle (the DONE cycle).
  - A late rvalid for a timed-out read is ignored only if it arrives in the DONE cycle. The bus must not deliver it later.
- Undefined: no counter; the bridge waits indefinitely; err_o=0.

Test Plan:
- Read, zero wait: ex_req_i=1, we=0, addr=0x1000_0004; gnt in cycle 1, rvalid with 0xDEADBEEF in cycle 2 -> hold_o=1 for cycles 0-2, ex_rdata_o=0xDEADBEEF and hold_o=0 in cycle 3.
- Write with 3-cycle grant delay: addr=0x2000_0000, wdata=0x12345678 -> m_addr_o and m_wdata_o stable for all 4 REQ cycles, hold_o drops 1 cycle after gnt, ex_rdata_o unchanged.
- Back-to-back: read then write with req held high -> exactly two m_req_o grant handshakes, one DONE between them, no duplicate request.
- Reset mid-RESP: assert rst while waiting for rvalid -> m_req_o=0 and hold_o=0 immediately; a later rvalid does not change ex_rdata_o (stays 0).
- With EX_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=8, read never answered -> err_o pulses once 8 cycles after REQ entry, ex_rdata_o=0, hold_o released.
- Idle: ex_req_i=0 for 20 cycles -> hold_o=0, m_req_o=0 throughout.
